// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer: FSM encoding, note-entry layout
// and the special field values that mark rests and the end of a song.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } seq_state_t;

    // Note entry layout: {period, dur}, duration in the low bits.
    localparam int MUSIC_PERIOD_W = 23;
    localparam int MUSIC_DUR_W    = 4;
    localparam int MUSIC_DUR_LSB  = 0;

    localparam int END_MARKER_DUR = 0;
    localparam int REST_PERIOD    = 0;

    // Counter width that holds dur*beat_cycles for any dur without truncation.
    function automatic int note_cnt_w(input int dur_w, input int beat_cycles);
        return dur_w + $clog2(beat_cycles);
    endfunction

endpackage

// File: rtl/music_note_timer.sv
// Note-length down-counter: loadable, freezable, with compare flags for the
// start of the articulation gap and for the end of the note.
module music_note_timer
    import music_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             hit_gap,
    output logic             hit_zero
);

    localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] count;

    // The counter parks at zero so a stalled GAP state cannot underflow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign hit_gap  = (count == GAP_CNT);
    assign hit_zero = (count == '0);

endmodule

// File: rtl/music_sequencer.sv
// Steps a registered note ROM at a fixed beat rate and drives the tone generator.
// Define MUSIC_SEQ_LOOP_EN to repeat the song until stop instead of playing once.
module music_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int ADDR_W      = 5,
    parameter int PERIOD_W    = MUSIC_PERIOD_W,
    parameter int DUR_W       = MUSIC_DUR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [PERIOD_W+DUR_W-1:0] rom_data,
    output logic [PERIOD_W-1:0]       tone_period,
    output logic                      tone_en,
    output logic                      busy,
    output logic                      done
);

    localparam int                CNT_W      = note_cnt_w(DUR_W, BEAT_CYCLES);
    localparam int                PERIOD_LSB = MUSIC_DUR_LSB + DUR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

    seq_state_t          state, state_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [PERIOD_W-1:0] period_n;
    logic                tmr_load;
    logic                tmr_en;
    logic                hit_gap;
    logic                hit_zero;

    logic [DUR_W-1:0]    rom_dur;
    logic [PERIOD_W-1:0] rom_period;
    logic [CNT_W-1:0]    note_len;
    logic [CNT_W-1:0]    load_val;

    assign rom_dur    = rom_data[MUSIC_DUR_LSB +: DUR_W];
    assign rom_period = rom_data[PERIOD_LSB +: PERIOD_W];

    // Full-width product so the longest note cannot wrap the counter.
    assign note_len = CNT_W'(rom_dur) * CNT_W'(BEAT_CYCLES);
    assign load_val = note_len - CNT_W'(1);

    assign tmr_en = !pause && ((state == ST_PLAY) || (state == ST_GAP));

    music_note_timer #(
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (load_val),
        .en       (tmr_en),
        .hit_gap  (hit_gap),
        .hit_zero (hit_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            tone_period <= '0;
        end else begin
            state       <= state_n;
            rom_addr    <= addr_n;
            tone_period <= period_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = rom_addr;
        period_n = tone_period;
        tmr_load = 1'b0;

        if (stop && (state != ST_IDLE)) begin
            state_n  = ST_IDLE;
            period_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_n = ST_FETCH;
                        addr_n  = '0;
                    end
                end

                ST_FETCH: begin
                    state_n = ST_LOAD;
                end

                ST_LOAD: begin
                    if (rom_dur == DUR_W'(END_MARKER_DUR)) begin
`ifdef MUSIC_SEQ_LOOP_EN
                        state_n = ST_FETCH;
                        addr_n  = '0;
`else
                        state_n  = ST_FINISH;
                        period_n = '0;
`endif
                    end else begin
                        state_n  = ST_PLAY;
                        period_n = rom_period;
                        tmr_load = 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (!pause && hit_gap) begin
                        state_n = ST_GAP;
                    end
                end

                // The last table slot ends the song even without an end marker.
                ST_GAP: begin
                    if (!pause && hit_zero) begin
                        if (rom_addr == LAST_ADDR) begin
`ifdef MUSIC_SEQ_LOOP_EN
                            state_n = ST_FETCH;
                            addr_n  = '0;
`else
                            state_n  = ST_FINISH;
                            period_n = '0;
`endif
                        end else begin
                            state_n = ST_FETCH;
                            addr_n  = rom_addr + ADDR_W'(1);
                        end
                    end
                end

                ST_FINISH: begin
                    state_n = ST_IDLE;
                end

                default: begin
                    state_n  = ST_IDLE;
                    period_n = '0;
                end
            endcase
        end
    end

    // Pause mutes combinationally so the tone stops in the same cycle.
    assign tone_en = (state == ST_PLAY) && (tone_period != PERIOD_W'(REST_PERIOD)) && !pause;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FINISH);

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: a note-level song model expands each
// table into a per-cycle expected waveform that a monitor checks cycle by cycle.
module tb_music_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int AW   = 3;
    localparam int PW   = 23;
    localparam int DW   = 4;
`ifdef MUSIC_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [PW+DW-1:0] rom_data = '0;
    logic [PW-1:0] tone_period;
    logic          tone_en;
    logic          busy;
    logic          done;

    logic [PW-1:0] tbl_per [8];
    logic [DW-1:0] tbl_dur [8];

    typedef struct {
        bit          en;
        int unsigned period;
        bit          busy;
        bit          done;
        int unsigned addr;
        bit          p;
        bit          s;
    } cyc_t;

    cyc_t wave[$];
    cyc_t exp_q[$];
    int   nchk = 0;
    int   nfail = 0;

    music_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .ADDR_W      (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .tone_period (tone_period),
        .tone_en     (tone_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Registered note ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= {tbl_per[rom_addr], tbl_dur[rom_addr]};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", nchk);
        $fatal(1, "watchdog");
    end

    function automatic cyc_t mk(bit en, int unsigned per, bit bz, bit dn, int unsigned addr);
        cyc_t c;
        c.en = en; c.period = per; c.busy = bz; c.done = dn; c.addr = addr;
        c.p = 1'b0; c.s = 1'b0;
        return c;
    endfunction

    // Song model: each entry costs a fetch and a load cycle, then dur*BEAT
    // cycles of which the last GAP are muted; pause inserts frozen cycles.
    task automatic build(input int pj, input int pk, input int pl, input int stop_in);
        int          addr = 0;
        int unsigned cur = 0;
        bit          fin = 1'b0;
        bit          pused = 1'b0;
        int          stop_at = stop_in;
        int          n;
        cyc_t        c;
        if (LOOP && stop_at < 0) stop_at = 150;
        wave.delete();
        while (!fin && (stop_at < 0 || wave.size() <= stop_at)) begin
            wave.push_back(mk(1'b0, cur, 1'b1, 1'b0, addr));
            wave.push_back(mk(1'b0, cur, 1'b1, 1'b0, addr));
            if (tbl_dur[addr] == 4'd0) begin
                if (LOOP) begin
                    addr = 0;
                end else begin
                    cur = 0;
                    wave.push_back(mk(1'b0, 0, 1'b1, 1'b1, addr));
                    fin = 1'b1;
                end
            end else begin
                cur = 32'(tbl_per[addr]);
                n = int'(tbl_dur[addr]) * BEAT;
                for (int t = 0; t < n; t++) begin
                    if (!pused && addr == pj && t == pk) begin
                        pused = 1'b1;
                        for (int i = 0; i < pl; i++) begin
                            c = mk(1'b0, cur, 1'b1, 1'b0, addr);
                            c.p = 1'b1;
                            wave.push_back(c);
                        end
                    end
                    wave.push_back(mk((t < n - GAP) && (cur != 0), cur, 1'b1, 1'b0, addr));
                end
                if (addr == 7) begin
                    if (LOOP) begin
                        addr = 0;
                    end else begin
                        cur = 0;
                        wave.push_back(mk(1'b0, 0, 1'b1, 1'b1, addr));
                        fin = 1'b1;
                    end
                end else begin
                    addr++;
                end
            end
        end
        if (fin) wave.push_back(mk(1'b0, 0, 1'b0, 1'b0, addr));
        if (stop_at >= 0 && stop_at < wave.size()) begin
            while (wave.size() > stop_at + 1) void'(wave.pop_back());
            wave[stop_at].s = 1'b1;
            wave.push_back(mk(1'b0, 0, 1'b0, 1'b0, wave[stop_at].addr));
        end
        wave.push_back(mk(1'b0, 0, 1'b0, 1'b0, wave[wave.size()-1].addr));
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        nchk++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drives start, then replays the pause/stop schedule cycle by cycle.
    task automatic run(input bit with_start);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        foreach (wave[i]) exp_q.push_back(wave[i]);
        for (int c = 0; c < wave.size(); c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            pause = wave[c].p;
            stop  = wave[c].s;
            start = wave[c].s & with_start;
        end
        @(posedge clk); #1;
        pause = 1'b0; stop = 1'b0; start = 1'b0;
        drain();
    endtask

    task automatic clear_tbl();
        for (int j = 0; j < 8; j++) begin
            tbl_per[j] = '0;
            tbl_dur[j] = '0;
        end
    endtask

    task automatic check_quiet(input string name);
        nchk++;
        if (tone_en !== 1'b0 || tone_period !== '0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0) begin
            nfail++;
            $display("FAIL %s: en/per/busy/done/addr got %b/%0d/%b/%b/%0d want 0/0/0/0/0",
                     name, tone_en, tone_period, busy, done, rom_addr);
        end
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nchk++;
            if (tone_en !== e.en || tone_period !== PW'(e.period) || busy !== e.busy ||
                done !== e.done || rom_addr !== AW'(e.addr)) begin
                nfail++;
                $display("FAIL cycle @%0t: en/per/busy/done/addr got %b/%0d/%b/%b/%0d want %b/%0d/%b/%b/%0d",
                         $time, tone_en, tone_period, busy, done, rom_addr,
                         e.en, e.period, e.busy, e.done, e.addr);
            end
        end
    end

    initial begin
        int pj, pk, pl, sa;
        clear_tbl();
        repeat (3) @(posedge clk);
        #1 check_quiet("reset_state");
        rst_n = 1'b1;

        // Single two-beat note followed by the end marker.
        clear_tbl();
        tbl_per[0] = 23'd1000; tbl_dur[0] = 4'd2;
        build(-1, 0, 0, -1);
        run(1'b0);

        // Rest then a tone.
        clear_tbl();
        tbl_per[0] = 23'd0;   tbl_dur[0] = 4'd1;
        tbl_per[1] = 23'd500; tbl_dur[1] = 4'd1;
        build(-1, 0, 0, -1);
        run(1'b0);

        // Five-cycle pause in the middle of the tone.
        clear_tbl();
        tbl_per[0] = 23'd1000; tbl_dur[0] = 4'd2;
        build(0, 6, 5, -1);
        run(1'b0);

        // Stop together with start mid-note.
        build(-1, 0, 0, 8);
        run(1'b1);

        // Asynchronous reset pulse mid-note.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        nchk++;
        if (tone_en !== 1'b1 || tone_period !== 23'd1000) begin
            nfail++;
            $display("FAIL pre_reset_play: en/per got %b/%0d want 1/1000", tone_en, tone_period);
        end
        #1 rst_n = 1'b0;
        #1 check_quiet("async_reset");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0));
        drain();

        // Stop and start together while idle.
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0));
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        drain();

        // Full table with no end marker, including the longest duration.
        for (int j = 0; j < 8; j++) begin
            tbl_per[j] = 23'(100 + j);
            tbl_dur[j] = 4'd1;
        end
        tbl_dur[3] = 4'd15;
        build(-1, 0, 0, LOOP ? 260 : -1);
        run(1'b0);

        // Randomised tables, pauses and stops.
        for (int it = 0; it < 15; it++) begin
            for (int j = 0; j < 8; j++) begin
                tbl_per[j] = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom_range(1, 8388607));
                if ($urandom_range(0, 9) == 0)      tbl_dur[j] = 4'd0;
                else if ($urandom_range(0, 7) == 0) tbl_dur[j] = 4'd15;
                else                                tbl_dur[j] = 4'($urandom_range(1, 3));
            end
            pj = int'($urandom_range(0, 7));
            pk = int'($urandom_range(0, 29));
            pl = int'($urandom_range(1, 6));
            sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 80));
            build(pj, pk, pl, sa);
            run(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
